huff_freq_count: RTL and testbench

Upstream stage of the Huffman tree builder. It counts the occurrences of 4-bit symbols in one input frame, with each count saturating at 15. It then emits one 8-bit node per symbol as {weight[7:4], symbol[3:0]}, in symbol order 0..15, over a valid/ready stream. That stream feeds the pairwise node sort/compare stage, which orders nodes on bits [7:4].

---
 rtl/huff_freq_count_pkg.sv | 24 ++
 rtl/huff_freq_count_if.sv | 22 ++
 rtl/huff_freq_count_cnt_table.sv | 32 +++
 rtl/huff_freq_count.sv | 82 ++++++++
 tb/tb_huff_freq_count.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/huff_freq_count_pkg.sv
// huff_pkg: shared widths, node field positions and state encoding for the Huffman front end
package huff_pkg;
  localparam int SYM_W      = 4;
  localparam int CNT_W      = 4;
  localparam int NODE_W     = CNT_W + SYM_W;
  localparam int NUM_SYM    = 2 ** SYM_W;
  localparam int WEIGHT_MSB = 7;
  localparam int WEIGHT_LSB = 4;
  localparam int SYM_MSB    = 3;
  localparam int SYM_LSB    = 0;
  typedef logic [SYM_W-1:0]  sym_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [NODE_W-1:0] node_t;
  typedef logic [SYM_W:0]    nz_t;
  localparam cnt_t CNT_MAX  = '1;
  localparam sym_t SYM_LAST = '1;
  typedef enum logic [1:0] {COUNT, LOAD, EMIT} state_t;
  function automatic node_t make_node(cnt_t w, sym_t s);
    node_t n;
    n[WEIGHT_MSB:WEIGHT_LSB] = w;
    n[SYM_MSB:SYM_LSB] = s;
    return n;
  endfunction
endpackage

// File: rtl/huff_freq_count_if.sv
// huff_freq_count_if: symbol input stream, node output stream and frame statistics
interface huff_freq_count_if;
  import huff_pkg::*;
  logic  sym_valid;
  sym_t  sym_in;
  logic  sym_last;
  logic  sym_ready;
  logic  node_valid;
  node_t node_out;
  logic  node_last;
  logic  node_ready;
  nz_t   nz_cnt;
  logic  sat_flag;
  modport slave (
    input  sym_valid, sym_in, sym_last, node_ready,
    output sym_ready, node_valid, node_out, node_last, nz_cnt, sat_flag
  );
  modport master (
    output sym_valid, sym_in, sym_last, node_ready,
    input  sym_ready, node_valid, node_out, node_last, nz_cnt, sat_flag
  );
endinterface

// File: rtl/huff_freq_count_cnt_table.sv
// huff_cnt_table: 16 saturating counters with increment, clear-on-read and async read port
module huff_cnt_table
  import huff_pkg::*;
(
  input  logic CLK,
  input  logic nRST,
  input  sym_t inc_addr,
  input  logic inc_en,
  input  sym_t clr_addr,
  input  logic clr_en,
  input  sym_t rd_addr,
  output cnt_t rd_data,
  output logic inc_first,
  output logic inc_sat
);
  cnt_t cnt [NUM_SYM];
  cnt_t cur;
  assign cur       = cnt[inc_addr];
  assign rd_data   = cnt[rd_addr];
  assign inc_first = inc_en && cur == '0;
  assign inc_sat   = inc_en && cur == CNT_MAX;
  genvar i;
  generate
    for (i = 0; i < NUM_SYM; i++) begin : g_cnt
      // clear wins over increment; a full counter holds instead of wrapping
      always_ff @(posedge CLK or negedge nRST)
        if (!nRST) cnt[i] <= '0;
        else if (clr_en && clr_addr == sym_t'(i)) cnt[i] <= '0;
        else if (inc_en && inc_addr == sym_t'(i) && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
    end
  endgenerate
endmodule

// File: rtl/huff_freq_count.sv
// huff_freq_count: counts 4-bit symbols per frame, then streams {weight,symbol} nodes 0..15
module huff_freq_count
  import huff_pkg::*;
(
  input logic CLK,
  input logic nRST,
  huff_freq_count_if.slave bus
);
  state_t state, state_nx;
  sym_t   idx, idx_nx, rd_addr;
  cnt_t   rd_data;
  node_t  node_out;
  nz_t    nz_cnt;
  logic   node_valid, node_last, sat_flag;
  logic   inc_en, inc_first, inc_sat, hs, done;
  assign inc_en  = state == COUNT && bus.sym_valid;
  assign hs      = state == EMIT && node_valid && bus.node_ready;
  assign done    = hs && idx == SYM_LAST;
  assign idx_nx  = idx + 1'b1;
  assign rd_addr = state == LOAD ? '0 : idx_nx;
  assign bus.sym_ready  = state == COUNT;
  assign bus.node_valid = node_valid;
  assign bus.node_out   = node_out;
  assign bus.node_last  = node_last;
  assign bus.nz_cnt     = nz_cnt;
  assign bus.sat_flag   = sat_flag;
  huff_cnt_table u_tab (
    .CLK      (CLK),
    .nRST     (nRST),
    .inc_addr (bus.sym_in),
    .inc_en   (inc_en),
    .clr_addr (idx),
    .clr_en   (hs),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .inc_first(inc_first),
    .inc_sat  (inc_sat)
  );
  // state register
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= COUNT;
    else state <= state_nx;
  // frame end moves to LOAD, LOAD lasts one cycle, the 16th handshake returns to COUNT
  always_comb begin
    state_nx = state;
    if (inc_en && bus.sym_last) state_nx = LOAD;
    else if (state == LOAD) state_nx = EMIT;
    else if (done) state_nx = COUNT;
  end
  // node output register; the table read port is aimed at the entry after idx so the next node is ready on each handshake
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      node_out   <= '0;
      node_valid <= 1'b0;
      node_last  <= 1'b0;
      idx        <= '0;
    end else if (state == LOAD) begin
      node_out   <= make_node(rd_data, '0);
      node_valid <= 1'b1;
      node_last  <= 1'b0;
      idx        <= '0;
    end else if (done) begin
      node_valid <= 1'b0;
      node_last  <= 1'b0;
    end else if (hs) begin
      node_out   <= make_node(rd_data, idx_nx);
      node_last  <= idx_nx == SYM_LAST;
      idx        <= idx_nx;
    end
  // frame statistics stay stable through emission and clear with the last handshake
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      nz_cnt   <= '0;
      sat_flag <= 1'b0;
    end else if (done) begin
      nz_cnt   <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (inc_first) nz_cnt <= nz_cnt + 1'b1;
      if (inc_sat) sat_flag <= 1'b1;
    end
endmodule

// File: tb/tb_huff_freq_count.sv
// tb_huff_freq_count: directed tests of symbol counting and node emission
module tb_huff_freq_count;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [3:0] exp_w [16];
  huff_freq_count_if bus();
  huff_freq_count dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_sym(input logic [3:0] s, input logic last);
    bus.sym_valid = 1'b1;
    bus.sym_in = s;
    bus.sym_last = last;
    step();
    bus.sym_valid = 1'b0;
    bus.sym_last = 1'b0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 16; i++) exp_w[i] = 4'd0;
  endtask

  // pat=1 drives node_ready 1,0,0,1 repeating; poke drives sym_valid on symbol 2 with last during emission
  task automatic collect(input bit pat, input int stop_at, input bit poke);
    int hs = 0;
    int cyc = 0;
    logic rdy;
    logic stall = 1'b0;
    logic [7:0] prev = 8'h00;
    logic [7:0] expn;
    while (hs < stop_at && cyc < 300) begin
      rdy = pat ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      bus.node_ready = rdy;
      if (poke) begin
        bus.sym_valid = 1'b1;
        bus.sym_in = 4'h2;
        bus.sym_last = 1'b1;
      end
      if (stall) begin
        tests++;
        if (bus.node_out !== prev || bus.node_valid !== 1'b1) begin
          fails++;
          $display("FAIL hold: node_out=%h valid=%b expected %h valid=1", bus.node_out, bus.node_valid, prev);
        end
      end
      if (bus.node_valid === 1'b1) begin
        if (poke) begin
          tests++;
          if (bus.sym_ready !== 1'b0) begin
            fails++;
            $display("FAIL sym_ready_emit: got %b expected 0", bus.sym_ready);
          end
        end
        if (rdy) begin
          expn = {exp_w[hs], hs[3:0]};
          tests++;
          if (bus.node_out !== expn || bus.node_last !== (hs == 15)) begin
            fails++;
            $display("FAIL node%0d: node_out=%h last=%b expected %h last=%b", hs, bus.node_out, bus.node_last, expn, hs == 15);
          end
          hs++;
        end
      end
      stall = bus.node_valid === 1'b1 && !rdy;
      prev = bus.node_out;
      step();
      cyc++;
    end
    bus.sym_valid = 1'b0;
    bus.sym_last = 1'b0;
    tests++;
    if (hs != stop_at) begin
      fails++;
      $display("FAIL timeout: handshakes=%0d expected %0d", hs, stop_at);
    end
    if (stop_at == 16) begin
      tests++;
      if (bus.sym_ready !== 1'b1 || bus.node_valid !== 1'b0 || bus.nz_cnt !== 5'd0 || bus.sat_flag !== 1'b0) begin
        fails++;
        $display("FAIL end_state: sym_ready=%b node_valid=%b nz=%0d sat=%b expected 1 0 0 0", bus.sym_ready, bus.node_valid, bus.nz_cnt, bus.sat_flag);
      end
    end
  endtask

  task automatic test_reset();
    bus.sym_valid = 1'b0;
    bus.sym_in = 4'h0;
    bus.sym_last = 1'b0;
    bus.node_ready = 1'b1;
    nRST = 1'b0;
    #12;
    tests++;
    if (bus.sym_ready !== 1'b1 || bus.node_valid !== 1'b0 || bus.node_out !== 8'h00 || bus.node_last !== 1'b0 || bus.nz_cnt !== 5'd0 || bus.sat_flag !== 1'b0) begin
      fails++;
      $display("FAIL reset: ready=%b valid=%b out=%h last=%b nz=%0d sat=%b expected 1 0 00 0 0 0", bus.sym_ready, bus.node_valid, bus.node_out, bus.node_last, bus.nz_cnt, bus.sat_flag);
    end
    nRST = 1'b1;
    step();
  endtask

  task automatic test_basic();
    clear_exp();
    exp_w[0] = 4'd1;
    exp_w[1] = 4'd2;
    exp_w[2] = 4'd3;
    bus.sym_last = 1'b1;
    step();
    bus.sym_last = 1'b0;
    tests++;
    if (bus.sym_ready !== 1'b1) begin
      fails++;
      $display("FAIL lone_last: sym_ready=%b expected 1", bus.sym_ready);
    end
    send_sym(4'h0, 1'b0);
    send_sym(4'h1, 1'b0);
    send_sym(4'h1, 1'b0);
    send_sym(4'h2, 1'b0);
    send_sym(4'h2, 1'b0);
    send_sym(4'h2, 1'b1);
    tests++;
    if (bus.node_valid !== 1'b0 || bus.sym_ready !== 1'b0) begin
      fails++;
      $display("FAIL load_cycle: valid=%b ready=%b expected 0 0", bus.node_valid, bus.sym_ready);
    end
    step();
    tests++;
    if (bus.node_valid !== 1'b1 || bus.node_out !== 8'h10) begin
      fails++;
      $display("FAIL latency: valid=%b out=%h expected 1 10", bus.node_valid, bus.node_out);
    end
    tests++;
    if (bus.nz_cnt !== 5'd3 || bus.sat_flag !== 1'b0) begin
      fails++;
      $display("FAIL basic_stats: nz=%0d sat=%b expected 3 0", bus.nz_cnt, bus.sat_flag);
    end
    collect(1'b0, 16, 1'b0);
  endtask

  task automatic test_saturate();
    clear_exp();
    exp_w[5] = 4'hF;
    for (int i = 0; i < 20; i++) send_sym(4'h5, 1'b0);
    send_sym(4'h5, 1'b1);
    step();
    tests++;
    if (bus.nz_cnt !== 5'd1 || bus.sat_flag !== 1'b1) begin
      fails++;
      $display("FAIL sat_stats: nz=%0d sat=%b expected 1 1", bus.nz_cnt, bus.sat_flag);
    end
    collect(1'b0, 16, 1'b0);
    exp_w[5] = 4'd1;
    send_sym(4'h5, 1'b1);
    step();
    tests++;
    if (bus.nz_cnt !== 5'd1 || bus.sat_flag !== 1'b0) begin
      fails++;
      $display("FAIL after_sat_stats: nz=%0d sat=%b expected 1 0", bus.nz_cnt, bus.sat_flag);
    end
    collect(1'b0, 16, 1'b0);
  endtask

  task automatic test_back_to_back();
    clear_exp();
    exp_w[7] = 4'd2;
    exp_w[9] = 4'd1;
    send_sym(4'h7, 1'b0);
    send_sym(4'h7, 1'b0);
    send_sym(4'h9, 1'b1);
    collect(1'b1, 16, 1'b1);
  endtask

  task automatic test_single_f();
    clear_exp();
    exp_w[15] = 4'd1;
    send_sym(4'hF, 1'b1);
    step();
    tests++;
    if (bus.nz_cnt !== 5'd1 || bus.sat_flag !== 1'b0) begin
      fails++;
      $display("FAIL single_stats: nz=%0d sat=%b expected 1 0", bus.nz_cnt, bus.sat_flag);
    end
    collect(1'b0, 16, 1'b0);
  endtask

  task automatic test_reset_mid();
    clear_exp();
    exp_w[9] = 4'd1;
    exp_w[12] = 4'd1;
    exp_w[15] = 4'd1;
    send_sym(4'h9, 1'b0);
    send_sym(4'hC, 1'b0);
    send_sym(4'hF, 1'b1);
    collect(1'b0, 8, 1'b0);
    nRST = 1'b0;
    #1;
    tests++;
    if (bus.node_valid !== 1'b0 || bus.sym_ready !== 1'b1 || bus.nz_cnt !== 5'd0) begin
      fails++;
      $display("FAIL mid_reset: valid=%b ready=%b nz=%0d expected 0 1 0", bus.node_valid, bus.sym_ready, bus.nz_cnt);
    end
    step();
    nRST = 1'b1;
    step();
    clear_exp();
    exp_w[3] = 4'd1;
    send_sym(4'h3, 1'b1);
    step();
    tests++;
    if (bus.nz_cnt !== 5'd1) begin
      fails++;
      $display("FAIL post_reset_stats: nz=%0d expected 1", bus.nz_cnt);
    end
    collect(1'b0, 16, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_back_to_back();
    test_single_f();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
